// File: rtl/time_set_controller_pkg.sv
// rtl/time_set_controller_pkg.sv - shared state encoding and BCD limits for the clock setters
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENTER,
      ST_LOAD,
      ST_ERROR
   } state_t;

   localparam logic [3:0] MAX_MS_HR      = 4'd1;
   localparam logic [3:0] MAX_LS_HR_TEEN = 4'd2;
   localparam logic [3:0] MAX_MS_MIN     = 4'd5;
   localparam logic [3:0] MAX_BCD        = 4'd9;

endpackage

// File: rtl/time_set_controller_if.sv
// rtl/time_set_controller_if.sv - keypad-side and counter-side signals of the time setter
interface time_set_if;

   logic       time_button;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       am_key;
   logic       enter;
   logic       cancel;
   logic       one_minute;
   logic [3:0] new_current_time_ls_min;
   logic [3:0] new_current_time_ms_min;
   logic [3:0] new_current_time_ls_hr;
   logic [3:0] new_current_time_ms_hr;
   logic       new_current_time_AM;
   logic       load_new_c;
   logic       one_minute_gated;
   logic       set_mode;
   logic       entry_error;

   modport master (
      output time_button, key_valid, key_digit, am_key, enter, cancel, one_minute,
      input  new_current_time_ls_min, new_current_time_ms_min,
      input  new_current_time_ls_hr, new_current_time_ms_hr, new_current_time_AM,
      input  load_new_c, one_minute_gated, set_mode, entry_error
   );

   modport slave (
      input  time_button, key_valid, key_digit, am_key, enter, cancel, one_minute,
      output new_current_time_ls_min, new_current_time_ms_min,
      output new_current_time_ls_hr, new_current_time_ms_hr, new_current_time_AM,
      output load_new_c, one_minute_gated, set_mode, entry_error
   );

endinterface

// File: rtl/bcd_time_validator.sv
// rtl/bcd_time_validator.sv - checks four BCD digits form a 12-hour time 01:00..12:59
module bcd_time_validator
   import clock_pkg::*;
(
   input  logic [3:0] i_ms_hr,
   input  logic [3:0] i_ls_hr,
   input  logic [3:0] i_ms_min,
   input  logic [3:0] i_ls_min,
   output logic       o_valid
);

   logic w_hr_ok;
   logic w_min_ok;

   always_comb begin
      w_hr_ok  = ((i_ms_hr == 4'd0) && (i_ls_hr <= MAX_BCD) && (i_ls_hr != 4'd0)) ||
                 ((i_ms_hr == MAX_MS_HR) && (i_ls_hr <= MAX_LS_HR_TEEN));
      w_min_ok = (i_ms_min <= MAX_MS_MIN) && (i_ls_min <= MAX_BCD);
      o_valid  = w_hr_ok && w_min_ok;
   end

endmodule

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - keypad time entry, validation and load sequencing for counting_logic
module time_set_controller
   import clock_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int ERR_CYCLES     = 8
) (
   input  logic      clk,
   input  logic      reset,
   time_set_if.slave bus
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int EW = (ERR_CYCLES > 2) ? $clog2(ERR_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [EW-1:0] ERR_LAST = EW'(ERR_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
   logic          r_am;
   logic [TW-1:0] r_timeout;
   logic [EW-1:0] r_err;
   logic          w_valid;
   logic          w_start, w_shift, w_toggle, w_to_inc;

   bcd_time_validator u_validator (
      .i_ms_hr (r_ms_hr),
      .i_ls_hr (r_ls_hr),
      .i_ms_min(r_ms_min),
      .i_ls_min(r_ls_min),
      .o_valid (w_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // One action per ENTER cycle; an out-of-range digit counts as an idle cycle.
   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_shift  = 1'b0;
      w_toggle = 1'b0;
      w_to_inc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.time_button) begin
               w_next  = ST_ENTER;
               w_start = 1'b1;
            end
         end
         ST_ENTER: begin
            if (bus.cancel)                                  w_next = ST_IDLE;
            else if (bus.enter)                              w_next = w_valid ? ST_LOAD : ST_ERROR;
            else if (bus.key_valid && bus.key_digit <= MAX_BCD) w_shift = 1'b1;
            else if (bus.am_key && !bus.key_valid)           w_toggle = 1'b1;
            else if (r_timeout == TO_LAST)                   w_next = ST_IDLE;
            else                                             w_to_inc = 1'b1;
         end
         ST_LOAD:  w_next = ST_IDLE;
         ST_ERROR: if (r_err == ERR_LAST) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ms_hr   <= 4'd0;
         r_ls_hr   <= 4'd0;
         r_ms_min  <= 4'd0;
         r_ls_min  <= 4'd0;
         r_am      <= 1'b0;
         r_timeout <= '0;
         r_err     <= '0;
      end else begin
         if (w_start) begin
            r_ms_hr  <= 4'd0;
            r_ls_hr  <= 4'd0;
            r_ms_min <= 4'd0;
            r_ls_min <= 4'd0;
         end else if (w_shift) begin
            r_ms_hr  <= r_ls_hr;
            r_ls_hr  <= r_ms_min;
            r_ms_min <= r_ls_min;
            r_ls_min <= bus.key_digit;
         end
         if (w_toggle) r_am <= ~r_am;
         if (w_start || w_shift || w_toggle) r_timeout <= '0;
         else if (w_to_inc)                  r_timeout <= r_timeout + 1'b1;
         r_err <= (r_state == ST_ERROR) ? r_err + 1'b1 : '0;
      end
   end

   assign bus.new_current_time_ms_hr  = r_ms_hr;
   assign bus.new_current_time_ls_hr  = r_ls_hr;
   assign bus.new_current_time_ms_min = r_ms_min;
   assign bus.new_current_time_ls_min = r_ls_min;
   assign bus.new_current_time_AM     = r_am;
   assign bus.load_new_c              = (r_state == ST_LOAD);
   assign bus.set_mode                = (r_state == ST_ENTER) || (r_state == ST_LOAD);
   assign bus.entry_error             = (r_state == ST_ERROR);
   assign bus.one_minute_gated        = bus.one_minute && (r_state == ST_IDLE);

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed and randomized checks of time_set_controller
module tb_time_set_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   time_set_if bus();

   time_set_controller #(.TIMEOUT_CYCLES(10), .ERR_CYCLES(8)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int   tests = 0;
   int   fails = 0;
   int   q[$];
   logic m_am;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] m_buf();
      return {4'(q[0]), 4'(q[1]), 4'(q[2]), 4'(q[3])};
   endfunction

   function automatic bit m_valid();
      int h = q[0] * 10 + q[1];
      int m = q[2] * 10 + q[3];
      return (h >= 1) && (h <= 12) && (m < 60);
   endfunction

   function automatic logic [15:0] dut_buf();
      return {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
              bus.new_current_time_ms_min, bus.new_current_time_ls_min};
   endfunction

   task automatic start();
      bus.time_button = 1'b1;
      cyc();
      bus.time_button = 1'b0;
      q = '{0, 0, 0, 0};
      check("start_set_mode", 32'(bus.set_mode), 32'd1);
      check("start_clear", 32'(dut_buf()), 32'd0);
   endtask

   task automatic key(int d);
      bus.key_valid = 1'b1;
      bus.key_digit = 4'(d);
      cyc();
      bus.key_valid = 1'b0;
      if (d <= 9) begin
         q.push_back(d);
         void'(q.pop_front());
      end
      check("key_buf", 32'(dut_buf()), 32'(m_buf()));
   endtask

   task automatic am();
      bus.am_key = 1'b1;
      cyc();
      bus.am_key = 1'b0;
      m_am = ~m_am;
      check("am_flag", 32'(bus.new_current_time_AM), 32'(m_am));
   endtask

   task automatic commit();
      bit v = m_valid();
      int n = 0;
      bit lseen = 0;
      bus.enter = 1'b1;
      cyc();
      bus.enter = 1'b0;
      check("commit_load", 32'(bus.load_new_c), 32'(v));
      check("commit_err", 32'(bus.entry_error), 32'(!v));
      if (v) begin
         check("load_buf", 32'(dut_buf()), 32'(m_buf()));
         check("load_am", 32'(bus.new_current_time_AM), 32'(m_am));
         check("load_set_mode", 32'(bus.set_mode), 32'd1);
         cyc();
         check("load_one_cycle", 32'(bus.load_new_c), 32'd0);
         check("load_set_mode_drop", 32'(bus.set_mode), 32'd0);
      end else begin
         check("err_set_mode", 32'(bus.set_mode), 32'd0);
         repeat (20) begin
            if (bus.entry_error) n++;
            if (bus.load_new_c) lseen = 1;
            cyc();
         end
         check("err_len", 32'(n), 32'd8);
         check("err_no_load", 32'(lseen), 32'd0);
         check("err_back_idle", 32'({bus.set_mode, bus.entry_error}), 32'd0);
      end
   endtask

   initial begin
      int h, m, nk;
      int cnt;
      bus.time_button = 0; bus.key_valid = 0; bus.key_digit = 0; bus.am_key = 0;
      bus.enter = 0; bus.cancel = 0; bus.one_minute = 0;
      reset = 1'b1;
      m_am = 1'b0;
      q = '{0, 0, 0, 0};
      cyc(); cyc();
      check("rst_outs", 32'({bus.load_new_c, bus.set_mode, bus.entry_error}), 32'd0);
      check("rst_buf", 32'(dut_buf()), 32'd0);
      check("rst_am", 32'(bus.new_current_time_AM), 32'd0);
      reset = 1'b0;
      cyc();

      start(); key(1); key(2); key(4); key(2); am(); commit();
      start(); key(1); key(3); key(0); key(0); commit();
      start(); key(0); key(0); key(0); key(0); commit();
      start(); key(0); key(9); key(6); key(0); commit();
      start(); key(0); key(9); key(5); key(9); commit();
      start(); key(1); key(2); key(1); key(0); key(3); key(0); commit();
      start(); key(1); key(12); key(1); key(5); key(15); key(0); commit();

      bus.one_minute = 1'b1; #1;
      check("tick_idle", 32'(bus.one_minute_gated), 32'd1);
      bus.one_minute = 1'b0;
      start();
      bus.one_minute = 1'b1; #1;
      check("tick_enter", 32'(bus.one_minute_gated), 32'd0);
      bus.one_minute = 1'b0;

      key(1); key(1); key(3); key(0);
      bus.cancel = 1'b1; bus.enter = 1'b1;
      cyc();
      bus.cancel = 1'b0; bus.enter = 1'b0;
      check("cancel_idle", 32'(bus.set_mode), 32'd0);
      check("cancel_no_load", 32'(bus.load_new_c), 32'd0);
      check("cancel_keeps_buf", 32'(dut_buf()), 32'(m_buf()));
      cyc();
      check("cancel_no_load2", 32'(bus.load_new_c), 32'd0);

      start();
      cnt = 1;
      repeat (20) begin
         cyc();
         if (bus.set_mode) cnt++;
         else break;
      end
      check("timeout_len", 32'(cnt), 32'd10);
      check("timeout_no_load", 32'(bus.load_new_c), 32'd0);

      start(); key(5); am();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      m_am = 1'b0;
      q = '{0, 0, 0, 0};
      check("rst_enter_idle", 32'({bus.set_mode, bus.load_new_c}), 32'd0);
      check("rst_enter_buf", 32'(dut_buf()), 32'(m_buf()));
      check("rst_enter_am", 32'(bus.new_current_time_AM), 32'(m_am));
      cyc();

      for (int it = 0; it < 40; it++) begin
         start();
         if ($urandom_range(0, 3) == 0) key($urandom_range(10, 15));
         if ($urandom_range(0, 1) == 1) begin
            h = $urandom_range(1, 12);
            m = $urandom_range(0, 59);
            key(h / 10); key(h % 10); key(m / 10); key(m % 10);
         end else begin
            nk = $urandom_range(1, 6);
            for (int k = 0; k < nk; k++) key($urandom_range(0, 9));
         end
         if ($urandom_range(0, 1) == 1) am();
         commit();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
